// File: rtl/pipelined_adder_pkg.sv
// Shared configuration helpers for the chunked, carry-registered add/sub pipeline.
package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Legal geometry: at least 2 bits, and the width splits into equal chunks.
  function automatic bit cfg_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational W-bit ripple adder; also exposes the carry into its MSB for overflow.
module add_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);
  logic [W:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .ci_i (c[i]),
      .s_o  (sum_o[i]),
      .co_o (c[i+1])
    );
  end

  assign cout_o = c[W];
  assign cmsb_o = c[W-1];
endmodule

// File: rtl/fa.sv
// One-bit full adder cell.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: one CHUNK-bit ripple per stage, carry registered between
// stages, valid/ready handshake with a combinational bubble-collapsing ready chain.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be >= 2 and a multiple of STAGES");
  end

  typedef struct packed {
    logic             vld;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } beat_t;

  beat_t                 in_beat;
  beat_t [STAGES-1:0]    stage_d, stage_q;
  logic  [STAGES:0]      load;

  // B is inverted up front and the carry field doubles as the stage-0 carry-in.
  always_comb begin
    in_beat       = '0;
    in_beat.vld   = in_valid;
    in_beat.sub   = sub;
    in_beat.a     = ina;
    in_beat.b     = inb ^ {WIDTH{sub}};
    in_beat.carry = sub;
  end

  assign load[STAGES] = !stage_q[STAGES-1].vld || out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    beat_t            src_b, d_b;
    logic [CHUNK-1:0] sum_c;
    logic             co_c, cm_c;

    if (k == 0) begin : g_head
      assign src_b = in_beat;
    end else begin : g_body
      assign src_b = stage_q[k-1];
    end

    assign load[k] = !stage_q[k].vld || load[k+1];

    add_chunk #(.W(CHUNK)) u_add (
      .a_i    (src_b.a[k*CHUNK +: CHUNK]),
      .b_i    (src_b.b[k*CHUNK +: CHUNK]),
      .cin_i  (src_b.carry),
      .sum_o  (sum_c),
      .cout_o (co_c),
      .cmsb_o (cm_c)
    );

    always_comb begin
      d_b                         = src_b;
      d_b.sum[k*CHUNK +: CHUNK]   = sum_c;
      d_b.carry                   = co_c;
      d_b.ovf                     = co_c ^ cm_c;
    end

    assign stage_d[k] = d_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (load[k]) stage_q[k] <= stage_d[k];
    end
  end

  // Consumed operand chunks and the sub tag are carried but never read downstream.
  logic unused_q;
  assign unused_q = ^stage_q;

  assign in_ready  = load[0];
  assign out_valid = stage_q[STAGES-1].vld;
  assign result    = stage_q[STAGES-1].sum;
  assign cout      = stage_q[STAGES-1].carry;
  assign ovf       = stage_q[STAGES-1].ovf;
endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized bench for pipelined_adder over four geometries with a scoreboard model.
module tb_pipelined_adder;
  localparam int NDUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] iv = '0, ordy = '0, sb = '0;
  logic [31:0]     a_v [NDUT];
  logic [31:0]     b_v [NDUT];
  wire  [NDUT-1:0] ir_w, ov_w, co_w, of_w;
  wire  [15:0]     r0;
  wire  [7:0]      r1, r2;
  wire  [31:0]     r3;

  initial for (int i = 0; i < NDUT; i++) begin a_v[i] = '0; b_v[i] = '0; end

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir_w[0]), .ina(a_v[0][15:0]),
    .inb(b_v[0][15:0]), .sub(sb[0]), .out_valid(ov_w[0]), .out_ready(ordy[0]),
    .result(r0), .cout(co_w[0]), .ovf(of_w[0]));
  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir_w[1]), .ina(a_v[1][7:0]),
    .inb(b_v[1][7:0]), .sub(sb[1]), .out_valid(ov_w[1]), .out_ready(ordy[1]),
    .result(r1), .cout(co_w[1]), .ovf(of_w[1]));
  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir_w[2]), .ina(a_v[2][7:0]),
    .inb(b_v[2][7:0]), .sub(sb[2]), .out_valid(ov_w[2]), .out_ready(ordy[2]),
    .result(r2), .cout(co_w[2]), .ovf(of_w[2]));
  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir_w[3]), .ina(a_v[3]),
    .inb(b_v[3]), .sub(sb[3]), .out_valid(ov_w[3]), .out_ready(ordy[3]),
    .result(r3), .cout(co_w[3]), .ovf(of_w[3]));

  typedef struct {
    logic [31:0] res;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int w_of(input int id);
    case (id)
      0: return 16;
      1: return 8;
      2: return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int s_of(input int id);
    case (id)
      0: return 4;
      1: return 1;
      2: return 8;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] res_of(input int id);
    case (id)
      0: return {16'b0, r0};
      1: return {24'b0, r1};
      2: return {24'b0, r2};
      default: return r3;
    endcase
  endfunction

  // Plain integer arithmetic: modulo result, no-borrow/carry flag, signed range check.
  function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b, input bit s);
    int     w = w_of(id);
    longint m = (longint'(1) << w) - 1;
    longint lim = longint'(1) << (w - 1);
    longint ua, ub, sa, sbv, r;
    exp_t   e;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    if (s) begin
      e.res = 32'((ua - ub) & m);
      e.co  = (ua >= ub);
    end else begin
      e.res = 32'((ua + ub) & m);
      e.co  = ((ua + ub) > m);
    end
    sa  = (ua >= lim) ? ua - (lim << 1) : ua;
    sbv = (ub >= lim) ? ub - (lim << 1) : ub;
    r   = s ? sa - sbv : sa + sbv;
    e.ov = (r >= lim) || (r < -lim);
    return e;
  endfunction

  // One cycle on DUT id: drive at negedge, observe just after, log accepted beats.
  task automatic step(input int id, input bit vin, input logic [31:0] a, input logic [31:0] b,
                      input bit s, input bit ordy_i, output bit acc, output bit ov,
                      output logic [31:0] res, output bit co, output bit of);
    @(negedge clk);
    iv[id] = vin; a_v[id] = a; b_v[id] = b; sb[id] = s; ordy[id] = ordy_i;
    #1;
    acc = vin && ir_w[id];
    ov  = ov_w[id];
    res = res_of(id);
    co  = co_w[id];
    of  = of_w[id];
    if (acc) exp_q.push_back(model(id, a, b, s));
  endtask

  task automatic test_reset();
    bit acc, ov, co, of;
    logic [31:0] res;
    int stale = 0;
    repeat (3) @(negedge clk);
    #1;
    for (int id = 0; id < NDUT; id++) begin
      n_cmp++;
      if (ov_w[id] !== 1'b0 || res_of(id) !== 32'h0 || co_w[id] !== 1'b0 || of_w[id] !== 1'b0 || ir_w[id] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_state id=%0d got v=%b r=%h c=%b o=%b rdy=%b exp v=0 r=0 c=0 o=0 rdy=1",
                 id, ov_w[id], res_of(id), co_w[id], of_w[id], ir_w[id]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1'b1, $urandom, $urandom, 1'($urandom), 1'b1, acc, ov, res, co, of);
    @(negedge clk); iv[0] = 1'b0; rst_n = 1'b0; #1;
    n_cmp++;
    if (ov_w[0] !== 1'b0) begin
      n_bad++; $display("FAIL reset_midstream got out_valid=%b exp 0", ov_w[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      step(0, 1'b0, 0, 0, 1'b0, 1'b1, acc, ov, res, co, of);
      if (ov) stale++;
    end
    n_cmp++;
    if (stale != 0 || ir_w[0] !== 1'b1) begin
      n_bad++; $display("FAIL reset_flush got stale=%0d in_ready=%b exp stale=0 in_ready=1", stale, ir_w[0]);
    end
  endtask

  task automatic test_directed(input int id);
    logic [31:0] tres [5] = '{32'h0100, 32'h0000, 32'hFFFF, 32'h8000, 32'h7FFF};
    bit          tco  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bit          tov  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int w = w_of(id), st = s_of(id);
    logic [31:0] mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    logic [31:0] va [5], vb [5];
    bit vs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bit acc, ov, co, of, got;
    logic [31:0] res;
    exp_t e;
    int lat;
    va = '{mask >> (w / 2), mask, 32'h0, mask >> 1, (mask >> 1) + 1};
    vb = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1};
    for (int v = 0; v < 5; v++) begin
      exp_q.delete();
      step(id, 1'b1, va[v], vb[v], vs[v], 1'b1, acc, ov, res, co, of);
      n_cmp++;
      if (!acc) begin
        n_bad++; $display("FAIL directed_accept id=%0d vec=%0d got in_ready=0 exp 1", id, v);
        continue;
      end
      e = exp_q.pop_front();
      if (id == 0) begin e.res = tres[v]; e.co = tco[v]; e.ov = tov[v]; end
      got = 1'b0; lat = 0;
      for (int j = 1; j <= 3 * st + 8; j++) begin
        step(id, 1'b0, 0, 0, 1'b0, 1'b1, acc, ov, res, co, of);
        if (ov) begin got = 1'b1; lat = j; break; end
      end
      n_cmp++;
      if (!got || lat != st || res !== e.res || co !== e.co || of !== e.ov) begin
        n_bad++;
        $display("FAIL directed id=%0d vec=%0d got seen=%b lat=%0d r=%h c=%b o=%b exp lat=%0d r=%h c=%b o=%b",
                 id, v, got, lat, res, co, of, st, e.res, e.co, e.ov);
      end
    end
  endtask

  task automatic test_streaming(input int id);
    int st = s_of(id);
    int n_emit = 0, first = -1, last = -1, t = 0;
    bit acc, ov, co, of;
    logic [31:0] res;
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 100 + st + 5; i++) begin
      step(id, i < 100, $urandom, $urandom, 1'($urandom), 1'b1, acc, ov, res, co, of);
      if (i < 100 && !acc) begin
        n_cmp++; n_bad++; $display("FAIL stream_ready id=%0d beat=%0d got in_ready=0 exp 1", id, i);
      end
      if (ov) begin
        n_emit++; if (first < 0) first = t; last = t;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL stream_extra id=%0d got unexpected r=%h exp none", id, res);
        end else begin
          e = exp_q.pop_front();
          if (res !== e.res || co !== e.co || of !== e.ov) begin
            n_bad++;
            $display("FAIL stream_data id=%0d got r=%h c=%b o=%b exp r=%h c=%b o=%b", id, res, co, of, e.res, e.co, e.ov);
          end
        end
      end
      t++;
    end
    n_cmp++;
    if (n_emit != 100 || first != st || last - first + 1 != n_emit || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL stream_rate id=%0d got emits=%0d first=%0d span=%0d left=%0d exp emits=100 first=%0d span=100 left=0",
               id, n_emit, first, last - first + 1, exp_q.size(), st);
    end
  endtask

  task automatic test_backpressure(input int id);
    int st = s_of(id);
    int n_acc = 0, n_emit = 0, unstable = 0;
    bit have = 1'b0, acc, ov, co, of;
    logic [31:0] res, head_r = '0;
    bit head_c = 1'b0, head_o = 1'b0;
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      step(id, 1'b1, $urandom, $urandom, 1'($urandom), 1'b0, acc, ov, res, co, of);
      if (acc) n_acc++;
      if (ov && !have) begin have = 1'b1; head_r = res; head_c = co; head_o = of; end
      else if (ov && (res !== head_r || co !== head_c || of !== head_o)) unstable++;
    end
    n_cmp++;
    if (n_acc != st || acc || !have || unstable != 0) begin
      n_bad++;
      $display("FAIL bp_fill id=%0d got accepts=%0d last_rdy=%b head=%b unstable=%0d exp accepts=%0d last_rdy=0 head=1 unstable=0",
               id, n_acc, acc, have, unstable, st);
    end
    if (have && exp_q.size() > 0) begin
      n_cmp++;
      if (head_r !== exp_q[0].res || head_c !== exp_q[0].co || head_o !== exp_q[0].ov) begin
        n_bad++; $display("FAIL bp_head id=%0d got r=%h exp r=%h", id, head_r, exp_q[0].res);
      end
    end
    n_acc = 0;
    for (int i = 0; i < 2 * st + 8; i++) begin
      step(id, i < 3, $urandom, $urandom, 1'($urandom), 1'b1, acc, ov, res, co, of);
      if (acc) n_acc++;
      if (ov) begin
        n_emit++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra id=%0d got unexpected r=%h exp none", id, res);
        end else begin
          e = exp_q.pop_front();
          if (res !== e.res || co !== e.co || of !== e.ov) begin
            n_bad++;
            $display("FAIL bp_drain id=%0d got r=%h c=%b o=%b exp r=%h c=%b o=%b", id, res, co, of, e.res, e.co, e.ov);
          end
        end
      end
    end
    n_cmp++;
    if (n_acc != 3 || n_emit != st + 3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_count id=%0d got accepts=%0d emits=%0d left=%0d exp accepts=3 emits=%0d left=0",
               id, n_acc, n_emit, exp_q.size(), st + 3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    for (int id = 0; id < NDUT; id++) begin
      test_directed(id);
      test_streaming(id);
      test_backpressure(id);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
